// File: rtl/usbfs_bit_rx.sv
// USB full-speed bit receiver: synchronizes DP/DN, recovers bits by edge re-centring, decodes NRZI,
// detects SYNC/EOP, removes stuffed bits and flags bus reset. Optional USBFS_RX_GLITCH_FILTER_EN adds a 3-sample majority filter.
module usbfs_bit_rx #(
  parameter int OSR        = 5,
  parameter int RST_CYCLES = 150
) (
  input  logic clk,
  input  logic rst,
  input  logic usb_dp,
  input  logic usb_dn,
  input  logic rx_inhibit,
  output logic rx_sta,
  output logic rx_ena,
  output logic rx_bit,
  output logic rx_fin,
  output logic bus_reset
);

  localparam int PW = $clog2(OSR);
  localparam int JW = $clog2(OSR + 1);
  localparam int CW = $clog2(RST_CYCLES + 1);
  localparam logic [PW-1:0] SAMPLE_PH = PW'(OSR / 2);
  localparam logic [PW-1:0] LAST_PH   = PW'(OSR - 1);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_EOP, S_ABORT} state_e;

  // Handshake: rx_sta/rx_ena/rx_fin are single-cycle strobes with no ready; the consumer must take
  // rx_bit in the same clock rx_ena is high, and at most one strobe is high per clock.

  logic [1:0] dp_sync, dn_sync;
  logic       line_dp, line_dn;

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_sync <= 2'b11;
      dn_sync <= 2'b00;
    end else begin
      dp_sync <= {dp_sync[0], usb_dp};
      dn_sync <= {dn_sync[0], usb_dn};
    end
  end

`ifdef USBFS_RX_GLITCH_FILTER_EN
  logic [1:0] dp_hist, dn_hist;
  logic       dp_filt, dn_filt;

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_hist <= 2'b11;
      dn_hist <= 2'b00;
      dp_filt <= 1'b1;
      dn_filt <= 1'b0;
    end else begin
      dp_hist <= {dp_hist[0], dp_sync[1]};
      dn_hist <= {dn_hist[0], dn_sync[1]};
      dp_filt <= (dp_sync[1] & dp_hist[0]) | (dp_sync[1] & dp_hist[1]) | (dp_hist[0] & dp_hist[1]);
      dn_filt <= (dn_sync[1] & dn_hist[0]) | (dn_sync[1] & dn_hist[1]) | (dn_hist[0] & dn_hist[1]);
    end
  end

  assign line_dp = dp_filt;
  assign line_dn = dn_filt;
`else
  assign line_dp = dp_sync[1];
  assign line_dn = dn_sync[1];
`endif

  logic is_j, is_k, is_se0;
  assign is_j   = line_dp & ~line_dn;
  assign is_k   = ~line_dp & line_dn;
  assign is_se0 = ~(is_j | is_k);

  logic [1:0]    last_line;
  logic          jk_edge;
  logic [PW-1:0] phase_q, phase_cur;
  logic          sample;

  // The first clock of a new J/K level counts as phase 0, so the sample lands mid-bit.
  assign jk_edge   = (is_j && last_line == 2'b01) || (is_k && last_line == 2'b10);
  assign phase_cur = jk_edge ? '0 : phase_q;
  assign sample    = (phase_cur == SAMPLE_PH);

  state_e       state_q, state_d;
  logic [2:0]   zeros_q, zeros_d;
  logic [2:0]   ones_q, ones_d;
  logic [JW-1:0] jcnt_q, jcnt_d;
  logic         prev_j_q, prev_j_d;
  logic         dec_bit;
  logic         sta_d, ena_d, bit_d, fin_d;
  logic [CW-1:0] se0_cnt_q;

  assign dec_bit = (is_j == prev_j_q);

  always_comb begin
    state_d  = state_q;
    zeros_d  = zeros_q;
    ones_d   = ones_q;
    jcnt_d   = jcnt_q;
    prev_j_d = prev_j_q;
    sta_d    = 1'b0;
    ena_d    = 1'b0;
    bit_d    = 1'b0;
    fin_d    = 1'b0;
    if (sample && !is_se0) prev_j_d = is_j;
    case (state_q)
      S_IDLE: begin
        if (sample && is_k) begin
          state_d = S_SYNC;
          zeros_d = 3'd0;
        end
      end
      S_SYNC: begin
        if (sample) begin
          if (is_se0) state_d = S_IDLE;
          else if (!dec_bit) zeros_d = (zeros_q == 3'd7) ? 3'd7 : zeros_q + 3'd1;
          else if (zeros_q >= 3'd3) begin
            sta_d   = 1'b1;
            state_d = S_DATA;
            ones_d  = 3'd0;
          end else state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (sample) begin
          if (is_se0) state_d = S_EOP;
          else if (ones_q == 3'd6) begin
            if (!dec_bit) ones_d = 3'd0;
            else begin
              state_d = S_ABORT;
              jcnt_d  = '0;
            end
          end else begin
            ena_d  = 1'b1;
            bit_d  = dec_bit;
            ones_d = dec_bit ? ones_q + 3'd1 : 3'd0;
          end
        end
      end
      S_EOP: begin
        if (sample) begin
          if (is_j) begin
            fin_d    = 1'b1;
            state_d  = S_IDLE;
            prev_j_d = 1'b1;
          end else if (is_k) begin
            state_d = S_ABORT;
            jcnt_d  = '0;
          end
        end
      end
      S_ABORT: begin
        // Leave only after a full bit time of continuous idle J.
        if (is_j) begin
          if (jcnt_q == JW'(OSR - 1)) begin
            state_d  = S_IDLE;
            prev_j_d = 1'b1;
            jcnt_d   = '0;
          end else jcnt_d = jcnt_q + 1'b1;
        end else jcnt_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
    if (rx_inhibit) begin
      state_d  = S_IDLE;
      ones_d   = 3'd0;
      prev_j_d = 1'b1;
      sta_d    = 1'b0;
      ena_d    = 1'b0;
      bit_d    = 1'b0;
      fin_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_line <= 2'b10;
      phase_q   <= '0;
      state_q   <= S_IDLE;
      zeros_q   <= 3'd0;
      ones_q    <= 3'd0;
      jcnt_q    <= '0;
      prev_j_q  <= 1'b1;
      rx_sta    <= 1'b0;
      rx_ena    <= 1'b0;
      rx_bit    <= 1'b0;
      rx_fin    <= 1'b0;
    end else begin
      last_line <= {line_dp, line_dn};
      phase_q   <= (phase_cur == LAST_PH) ? '0 : phase_cur + 1'b1;
      state_q   <= state_d;
      zeros_q   <= zeros_d;
      ones_q    <= ones_d;
      jcnt_q    <= jcnt_d;
      prev_j_q  <= prev_j_d;
      rx_sta    <= sta_d;
      rx_ena    <= ena_d;
      rx_bit    <= bit_d;
      rx_fin    <= fin_d;
    end
  end

  // SE0 timer saturates so a held reset pulses bus_reset only once.
  always_ff @(posedge clk) begin
    if (rst) begin
      se0_cnt_q <= '0;
      bus_reset <= 1'b0;
    end else begin
      if (!is_se0) se0_cnt_q <= '0;
      else if (se0_cnt_q != CW'(RST_CYCLES)) se0_cnt_q <= se0_cnt_q + 1'b1;
      bus_reset <= is_se0 && (se0_cnt_q == CW'(RST_CYCLES - 1));
    end
  end

endmodule

// File: tb/tb_usbfs_bit_rx.sv
// Directed bench for usbfs_bit_rx: builds NRZI/bit-stuffed line symbols from payload bytes and
// checks every strobe against an expected event queue derived from the payload.
module tb_usbfs_bit_rx;

  localparam int OSR        = 5;
  localparam int RST_CYCLES = 150;
`ifdef USBFS_RX_GLITCH_FILTER_EN
  localparam int LAT_EXTRA = 2;
`else
  localparam int LAT_EXTRA = 0;
`endif

  localparam logic [1:0] L_J   = 2'b10;
  localparam logic [1:0] L_K   = 2'b01;
  localparam logic [1:0] L_SE0 = 2'b00;

  localparam logic [2:0] EV_STA = 3'b100;
  localparam logic [2:0] EV_FIN = 3'b110;
  localparam logic [2:0] EV_B0  = 3'b010;
  localparam logic [2:0] EV_B1  = 3'b011;

  logic clk = 1'b0;
  logic rst, usb_dp, usb_dn, rx_inhibit;
  logic rx_sta, rx_ena, rx_bit, rx_fin, bus_reset;

  always #5 clk = ~clk;

  usbfs_bit_rx #(.OSR(OSR), .RST_CYCLES(RST_CYCLES)) dut (
    .clk(clk), .rst(rst), .usb_dp(usb_dp), .usb_dn(usb_dn), .rx_inhibit(rx_inhibit),
    .rx_sta(rx_sta), .rx_ena(rx_ena), .rx_bit(rx_bit), .rx_fin(rx_fin), .bus_reset(bus_reset)
  );

  logic [2:0] exp_q[$];
  logic       pay[$];
  logic [1:0] sym[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ena_cnt = 0;
  int br_count = 0;
  int br_cyc = 0;
  bit br_allow = 1'b0;
  bit mon_en = 1'b0;
  bit flush_pending = 1'b0;
  bit glitch_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every strobe must be the next expected event.
  always @(negedge clk) begin
    if (mon_en) begin
      int n;
      logic [2:0] act, e;
      n = int'(rx_sta) + int'(rx_ena) + int'(rx_fin);
      if (n > 1) begin
        total++; bad++;
        $display("FAIL exclusive: sta/ena/fin=%b%b%b want at most one high", rx_sta, rx_ena, rx_fin);
      end else if (n == 1) begin
        act = rx_sta ? EV_STA : (rx_fin ? EV_FIN : {2'b01, rx_bit});
        if (rx_ena) ena_cnt++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL strobe: got event %b at cycle %0d, want none", act, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e !== act) begin
            bad++;
            $display("FAIL strobe: got event %b at cycle %0d, want %b", act, cyc, e);
          end
        end
      end
      if (bus_reset) begin
        br_count++;
        br_cyc = cyc;
        if (!br_allow) begin
          total++; bad++;
          $display("FAIL bus_reset: got 1 at cycle %0d, want 0", cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    if (flush_pending) begin
      exp_q.delete();
      flush_pending = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      {usb_dp, usb_dn} = L_J;
    end
  endtask

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) pay.push_back(b[i]);
  endtask

  function automatic logic [15:0] crc_of_pay(input int from);
    logic [15:0] crc;
    logic fb;
    crc = 16'hFFFF;
    for (int i = from; i < pay.size(); i++) begin
      fb  = pay[i] ^ crc[0];
      crc = crc >> 1;
      if (fb) crc = crc ^ 16'hA001;
    end
    return ~crc;
  endfunction

  // NRZI from idle J: a 0 toggles the level. Returns the number of inserted stuff bits.
  function automatic int encode(input bit stuff_en);
    logic [1:0] lvl;
    int run, stuffed;
    logic [7:0] sync_bits;
    sym.delete();
    lvl = L_J;
    run = 0;
    stuffed = 0;
    sync_bits = 8'b1000_0000;
    for (int i = 0; i < 8; i++) begin
      if (!sync_bits[i]) lvl = ~lvl;
      sym.push_back(lvl);
    end
    for (int i = 0; i < pay.size(); i++) begin
      if (!pay[i]) lvl = ~lvl;
      sym.push_back(lvl);
      if (stuff_en) begin
        run = pay[i] ? run + 1 : 0;
        if (run == 6) begin
          lvl = ~lvl;
          sym.push_back(lvl);
          run = 0;
          stuffed++;
        end
      end
    end
    sym.push_back(L_SE0);
    sym.push_back(L_SE0);
    sym.push_back(L_J);
    return stuffed;
  endfunction

  // Expected events: SYNC strobe, the payload bits, then EOP; an unstuffed run of seven ones
  // ends the packet silently just before the seventh one.
  task automatic model_expect(input bit stuff_en);
    int run;
    exp_q.push_back(EV_STA);
    run = 0;
    for (int i = 0; i < pay.size(); i++) begin
      if (!stuff_en && pay[i] && run == 6) return;
      exp_q.push_back(pay[i] ? EV_B1 : EV_B0);
      run = pay[i] ? run + 1 : 0;
    end
    exp_q.push_back(EV_FIN);
  endtask

  // mode 1: each bit lasts 4 or 6 clocks, drift since the last level change kept within +-2.
  // cut_kind 1 asserts rst, 2 asserts rx_inhibit at the start of symbol cut_idx.
  task automatic drive_pkt(input int mode, input int cut_idx, input int cut_kind);
    int p, dev;
    dev = 0;
    for (int i = 0; i < sym.size(); i++) begin
      p = OSR;
      if (mode == 1 && i < sym.size() - 3) begin
        if (i == 0 || sym[i] != sym[i-1]) dev = 0;
        p = ($urandom_range(0, 1) == 1) ? 6 : 4;
        if (dev + p - 5 > 2 || dev + p - 5 < -2) p = 10 - p;
        dev = dev + p - 5;
      end
      for (int c = 0; c < p; c++) begin
        tick();
        if (c == 0 && i == cut_idx) begin
          if (cut_kind == 1) rst = 1'b1;
          if (cut_kind == 2) rx_inhibit = 1'b1;
          flush_pending = 1'b1;
        end
        {usb_dp, usb_dn} = sym[i];
        if (glitch_en && c == 1 && sym[i] == L_J && i >= 10 && i < sym.size() - 3 && (i % 3) == 0)
          {usb_dp, usb_dn} = L_K;
      end
    end
  endtask

  task automatic run_token(input string name);
    int s;
    pay.delete();
    push_byte(8'h2D); push_byte(8'h00); push_byte(8'h10);
    s = encode(1'b1);
    model_expect(1'b1);
    drive_pkt(0, -1, 0);
    idle(30);
    check({name, " leftover"}, exp_q.size(), 0);
  endtask

  initial begin
    logic [23:0] pv;
    logic [15:0] sv;
    logic [15:0] crc;
    int s;
    rst = 1'b1; rx_inhibit = 1'b0;
    {usb_dp, usb_dn} = L_J;
    repeat (4) tick();
    check("reset outputs", int'({rx_sta, rx_ena, rx_bit, rx_fin, bus_reset}), 0);
    rst = 1'b0;
    mon_en = 1'b1;
    idle(10);

    // Token 2D 00 10, plus pins on the stimulus model itself.
    pay.delete();
    push_byte(8'h2D); push_byte(8'h00); push_byte(8'h10);
    for (int i = 0; i < 24; i++) pv[i] = pay[i];
    check("token bit order", int'(pv), int'(24'h10002D));
    s = encode(1'b1);
    check("token stuff count", s, 0);
    for (int i = 0; i < 8; i++) sv[15-2*i -: 2] = sym[i];
    check("sync line levels", int'(sv), int'(16'h6665));
    check("eop tail", int'({sym[sym.size()-3], sym[sym.size()-2], sym[sym.size()-1]}), int'(6'b000010));
    model_expect(1'b1);
    check("token events", exp_q.size(), 26);
    ena_cnt = 0;
    drive_pkt(0, -1, 0);
    idle(30);
    check("token leftover", exp_q.size(), 0);
    check("token ena count", ena_cnt, 24);

    // DATA0 C3 FF FF + CRC16: stuffed zeros are dropped.
    pay.delete();
    push_byte(8'hC3); push_byte(8'hFF); push_byte(8'hFF);
    s = encode(1'b1);
    check("data0 stuff count", s, 3);
    crc = crc_of_pay(8);
    push_byte(crc[7:0]); push_byte(crc[15:8]);
    s = encode(1'b1);
    model_expect(1'b1);
    ena_cnt = 0;
    drive_pkt(0, -1, 0);
    idle(30);
    check("data0 leftover", exp_q.size(), 0);
    check("data0 ena count", ena_cnt, 40);

    // Seven ones with no stuffing: packet aborts, no rx_fin.
    pay.delete();
    push_byte(8'h2D); push_byte(8'h7F);
    s = encode(1'b0);
    model_expect(1'b0);
    check("stuff error events", exp_q.size(), 15);
    drive_pkt(0, -1, 0);
    idle(30);
    check("stuff error leftover", exp_q.size(), 0);
    run_token("after abort");

    // Bit periods of 4 or 6 clocks.
    for (int r = 0; r < 3; r++) begin
      pay.delete();
      push_byte(8'h5A); push_byte(8'hFF); push_byte(8'h00); push_byte(8'h3C); push_byte(8'hE7);
      s = encode(1'b1);
      model_expect(1'b1);
      drive_pkt(1, -1, 0);
      idle(30);
      check("jitter leftover", exp_q.size(), 0);
    end

    // Long SE0 in idle: one bus_reset, no packet strobes.
    br_count = 0;
    br_allow = 1'b1;
    tick();
    {usb_dp, usb_dn} = L_SE0;
    s = cyc;
    for (int i = 1; i < 160; i++) begin
      tick();
      {usb_dp, usb_dn} = L_SE0;
    end
    idle(20);
    br_allow = 1'b0;
    check("bus_reset count", br_count, 1);
    check("bus_reset cycle", br_cyc - s, RST_CYCLES + 2 + LAT_EXTRA);

    // rst mid-packet, then a clean token.
    pay.delete();
    push_byte(8'h2D); push_byte(8'h00); push_byte(8'h10);
    s = encode(1'b1);
    model_expect(1'b1);
    drive_pkt(0, 14, 1);
    idle(10);
    rst = 1'b0;
    idle(10);
    run_token("after rst");

    // rx_inhibit mid-packet, then a clean token.
    pay.delete();
    push_byte(8'hC3); push_byte(8'hA5); push_byte(8'h0F);
    s = encode(1'b1);
    model_expect(1'b1);
    drive_pkt(0, 20, 2);
    idle(10);
    rx_inhibit = 1'b0;
    idle(10);
    run_token("after inhibit");

`ifdef USBFS_RX_GLITCH_FILTER_EN
    glitch_en = 1'b1;
    pay.delete();
    push_byte(8'h2D); push_byte(8'h00); push_byte(8'h10); push_byte(8'hFF);
    s = encode(1'b1);
    model_expect(1'b1);
    drive_pkt(0, -1, 0);
    idle(30);
    glitch_en = 1'b0;
    check("glitch leftover", exp_q.size(), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
